// File: rtl/dp_jtag_pkg.sv
// Shared JTAG constants: IR capture pattern, default IR width and IR opcodes.
package dp_jtag_pkg;

    localparam int unsigned IR_W_DEFAULT = 5;

    localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;

    localparam logic [IR_W_DEFAULT-1:0] IR_IDCODE = 5'b00001;
    localparam logic [IR_W_DEFAULT-1:0] IR_BYPASS = 5'b11111;
    localparam logic [IR_W_DEFAULT-1:0] IR_EXTEST = 5'b00000;

endpackage

// File: rtl/dp_ir_reg.sv
// JTAG instruction register: capture/shift register plus update register.
// Define DP_IR_LEN_CHECK_EN to add the sticky ir_err short-scan length check.
module dp_ir_reg
    import dp_jtag_pkg::*;
#(
    parameter int unsigned     IR_W     = IR_W_DEFAULT,
    parameter logic [IR_W-1:0] IR_RESET = IR_W'(IR_IDCODE)
) (
    input  logic            iclk,
    input  logic            resetn,
    input  logic            tlr,
    input  logic            capture_ir,
    input  logic            shift_ir,
    input  logic            update_ir,
    input  logic            tdi,
    input  logic [IR_W-3:0] status_in,
    output logic            tdo,
    output logic [IR_W-1:0] ir_out,
    output logic            ir_upd
`ifdef DP_IR_LEN_CHECK_EN
    ,
    output logic            ir_err
`endif
);

    logic [IR_W-1:0] sr_q, sr_d;
    logic [IR_W-1:0] ur_q, ur_d;
    logic            upd_q, upd_d;

`ifdef DP_IR_LEN_CHECK_EN
    localparam int unsigned CNT_W = $clog2(IR_W + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Next-state: tlr > capture > shift > update; only the highest acts.
    always_comb begin
        sr_d  = sr_q;
        ur_d  = ur_q;
        upd_d = 1'b0;
`ifdef DP_IR_LEN_CHECK_EN
        cnt_d = cnt_q;
        err_d = err_q;
`endif
        if (tlr) begin
            sr_d = IR_RESET;
            ur_d = IR_RESET;
`ifdef DP_IR_LEN_CHECK_EN
            cnt_d = '0;
            err_d = 1'b0;
`endif
        end else if (capture_ir) begin
            sr_d = {status_in, IR_CAPTURE_PAT};
`ifdef DP_IR_LEN_CHECK_EN
            cnt_d = '0;
            err_d = 1'b0;
`endif
        end else if (shift_ir) begin
            sr_d = {tdi, sr_q[IR_W-1:1]};
`ifdef DP_IR_LEN_CHECK_EN
            if (cnt_q != CNT_W'(IR_W)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`endif
        end else if (update_ir) begin
`ifdef DP_IR_LEN_CHECK_EN
            // A short scan leaves the active instruction untouched.
            if (cnt_q == CNT_W'(IR_W)) begin
                ur_d  = sr_q;
                upd_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
`else
            ur_d  = sr_q;
            upd_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            sr_q  <= IR_RESET;
            ur_q  <= IR_RESET;
            upd_q <= 1'b0;
`ifdef DP_IR_LEN_CHECK_EN
            cnt_q <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            sr_q  <= sr_d;
            ur_q  <= ur_d;
            upd_q <= upd_d;
`ifdef DP_IR_LEN_CHECK_EN
            cnt_q <= cnt_d;
            err_q <= err_d;
`endif
        end
    end

    assign tdo    = sr_q[0];
    assign ir_out = ur_q;
    assign ir_upd = upd_q;
`ifdef DP_IR_LEN_CHECK_EN
    assign ir_err = err_q;
`endif

endmodule
